hc86_mismatch_mon: RTL and testbench

//   Windowed mismatch monitor; sits directly downstream of the hc86 XOR gate.
//   hc86 compares two bit streams (a,b); its 'out' is 1 on every mismatch.

---
 rtl/hc86_mismatch_mon.sv | 105 ++++++++++
 tb/tb_hc86_mismatch_mon.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hc86_mismatch_mon.sv
// rtl/hc86_mismatch_mon.sv - windowed mismatch counter with threshold alarm behind the hc86 XOR
// Optional first-mismatch capture (first_vld/first_idx) when FIRST_ERR_EN is defined.
module hc86_mismatch_mon #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic [CNT_W-1:0] thresh,
   input  logic             xin,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
`ifdef FIRST_ERR_EN
   output logic             first_vld,
   output logic [WIN_W-1:0] first_idx,
`endif
   output logic             alarm
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic             sync1;
   logic             xs;
   logic [WIN_W-1:0] wcnt;
   logic [CNT_W-1:0] thresh_r;

   // xin is asynchronous to clk; only the second flop is ever consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         xs    <= 1'b0;
      end else begin
         sync1 <= xin;
         xs    <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         err_cnt  <= '0;
         alarm    <= 1'b0;
         wcnt     <= '0;
         thresh_r <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  thresh_r <= thresh;
                  err_cnt  <= '0;
                  alarm    <= 1'b0;
                  wcnt     <= win_len;
                  state    <= (win_len == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (xs && (err_cnt != {CNT_W{1'b1}}))
                  err_cnt <= err_cnt + CNT_W'(1);
               wcnt <= wcnt - WIN_W'(1);
               if (wcnt == WIN_W'(1))
                  state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b1;
               alarm <= (err_cnt >= thresh_r);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_RUN) || (state == S_DONE);

`ifdef FIRST_ERR_EN
   logic [WIN_W-1:0] win_len_r;

   // sample index is recovered from the down-counter: len - remaining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_len_r <= '0;
         first_vld <= 1'b0;
         first_idx <= '0;
      end else begin
         if ((state == S_IDLE) && start) begin
            win_len_r <= win_len;
            first_vld <= 1'b0;
            first_idx <= '0;
         end else if ((state == S_RUN) && xs && !first_vld) begin
            first_vld <= 1'b1;
            first_idx <= win_len_r - wcnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hc86_mismatch_mon.sv
// tb/tb_hc86_mismatch_mon.sv - directed self-checking bench for hc86_mismatch_mon
// Exercises first-mismatch ports only when FIRST_ERR_EN is defined.
`timescale 1ns/1ps
module tb_hc86_mismatch_mon;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] win_len;
   logic [7:0]  thresh;
   logic        xin;
   logic        busy, done, alarm;
   logic [7:0]  err_cnt;
   logic        s_busy, s_done, s_alarm;
   logic [3:0]  s_err_cnt;
`ifdef FIRST_ERR_EN
   logic        first_vld;
   logic [15:0] first_idx;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hc86_mismatch_mon #(.CNT_W(8), .WIN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
      .thresh(thresh), .xin(xin), .busy(busy), .done(done),
      .err_cnt(err_cnt),
`ifdef FIRST_ERR_EN
      .first_vld(first_vld), .first_idx(first_idx),
`endif
      .alarm(alarm)
   );

   // Narrow-counter instance for the saturation case, sharing stimulus
   hc86_mismatch_mon #(.CNT_W(4), .WIN_W(16)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
      .thresh(thresh[3:0]), .xin(xin), .busy(s_busy), .done(s_done),
      .err_cnt(s_err_cnt),
`ifdef FIRST_ERR_EN
      .first_vld(), .first_idx(),
`endif
      .alarm(s_alarm)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Sample i of the window sees xin as driven before edge T+i-1 (2-flop sync)
   task automatic run_window(input string tag, input int len, input int th,
                             input logic [63:0] pat, input int exp_err, input logic exp_alarm);
      int done_edge;
      int done_cnt;
      done_edge = -1;
      done_cnt  = 0;
      start   = 1'b0;
      win_len = 16'(len);
      thresh  = 8'(th);
      xin     = pat[0];
      tick();
      xin   = pat[1];
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      for (int k = 1; k <= len + 3; k++) begin
         xin = (k + 1 < 64) ? pat[k+1] : 1'b0;
         tick();
         if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = k;
         end
      end
      check({tag, "_done_edge"}, done_edge, len + 1);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_alarm"}, alarm, exp_alarm);
   endtask

   initial begin
      int done_edge;
      int done_cnt;

      // 1: reset with active-looking inputs
      rst_n = 1'b0; start = 1'b1; xin = 1'b1; win_len = 16'd5; thresh = 8'd1;
      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_alarm", alarm, 1'b0);
      check("rst_sat_err", s_err_cnt, 0);
`ifdef FIRST_ERR_EN
      check("rst_first_vld", first_vld, 1'b0);
`endif
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 1'b0);

      // 2: eight-sample windows, 4 then 2 mismatches against thresh 3
      run_window("w8_4err", 8, 3, 64'h55, 4, 1'b1);
      run_window("w8_2err", 8, 3, 64'h81, 2, 1'b0);

      // 3: 40 constant mismatches; 4-bit counter must pin at 15
      run_window("w40", 40, 20, {64{1'b1}}, 40, 1'b1);
      check("sat_err_cnt", s_err_cnt, 15);
      check("sat_alarm", s_alarm, 1'b1);

      // 4: zero-length windows
      run_window("w0_th0", 0, 0, 64'h0, 0, 1'b1);
      run_window("w0_th4", 0, 4, 64'h0, 0, 1'b0);

      // start held high: DONE-cycle start ignored, next IDLE cycle accepts
      xin = 1'b0; win_len = 16'd3; thresh = 8'd1; start = 1'b1;
      tick();
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 4) begin
            check("hold_done_k4", done, 1'b1);
            check("hold_busy_k4", busy, 1'b0);
         end
         if (k == 5) check("hold_busy_k5", busy, 1'b1);
         if (k == 9) check("hold_done_k9", done, 1'b1);
      end
      start = 1'b0;
      repeat (3) tick();

      // 5: start during RUN is ignored (length and threshold kept)
      xin = 1'b1; win_len = 16'd10; thresh = 8'd5;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      win_len = 16'd2; thresh = 8'd200; start = 1'b1;
      tick();
      start = 1'b0;
      done_edge = -1;
      for (int k = 6; k <= 13; k++) begin
         tick();
         if (done && done_edge < 0) done_edge = k;
      end
      check("ign_done_edge", done_edge, 11);
      check("ign_err_cnt", err_cnt, 10);
      check("ign_alarm", alarm, 1'b1);

      // reset mid-window: immediate clear, no done afterwards
      win_len = 16'd10; thresh = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_err_cnt", err_cnt, 0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_alarm", alarm, 1'b0);
      tick();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (done) done_cnt++;
      end
      check("mid_rst_no_done", done_cnt, 0);
      check("mid_rst_idle", busy, 1'b0);

`ifdef FIRST_ERR_EN
      // 6: first mismatch at sample 5, later one at 7 must not overwrite
      run_window("first5", 10, 1, 64'hA0, 2, 1'b1);
      check("first_vld_set", first_vld, 1'b1);
      check("first_idx_5", first_idx, 5);
      run_window("first_none", 10, 1, 64'h0, 0, 1'b0);
      check("first_vld_clr", first_vld, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
